// File: rtl/issue_sched.sv
// In-order dual-issue scheduler: scoreboard hazard checks, pair rules and
// CSR/invalid serialization FSM between decode lanes and two execute pipes.
package issue_sched_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SERIAL = 2'd2, WAIT = 2'd3} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [7:0]  cls;
  } slot_t;

  localparam int C_LSU = 1;
  localparam int C_BR  = 2;
  localparam int C_MUL = 3;
  localparam int C_DIV = 4;
  localparam int C_CSR = 5;
  localparam int C_RDV = 6;
  localparam int C_INV = 7;
endpackage

// Per-lane register decode and scoreboard lookup.
module issue_sched_lane (
  input  logic [14:0] regs,
  input  logic        rd_valid,
  input  logic        muldiv,
  input  logic [31:0] pend,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        rd_wr,
  output logic        hazard,
  output logic        sb_set
);
  // regs packs {rs2, rs1, rd}
  assign rd     = regs[4:0];
  assign rs1    = regs[9:5];
  assign rs2    = regs[14:10];
  assign rd_wr  = rd_valid & (rd != 5'd0);
  assign hazard = pend[rs1] | pend[rs2] | (rd_valid & pend[rd]);
  assign sb_set = muldiv & rd_wr;
endmodule

module issue_sched
  import issue_sched_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        slot0_valid_i,
  input  logic [31:0] slot0_instr_i,
  input  logic [31:0] slot0_pc_i,
  input  logic [7:0]  slot0_class_i,
  output logic        slot0_accept_o,
  input  logic        slot1_valid_i,
  input  logic [31:0] slot1_instr_i,
  input  logic [31:0] slot1_pc_i,
  input  logic [7:0]  slot1_class_i,
  output logic        slot1_accept_o,
  output logic        issue0_valid_o,
  output logic [31:0] issue0_instr_o,
  output logic [31:0] issue0_pc_o,
  output logic [7:0]  issue0_class_o,
  input  logic        issue0_accept_i,
  output logic        issue1_valid_o,
  output logic [31:0] issue1_instr_o,
  output logic [31:0] issue1_pc_o,
  output logic [7:0]  issue1_class_o,
  input  logic        issue1_accept_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        branch_request_i,
  input  logic        pipe_idle_i,
  output logic [31:0] dual_cnt_o,
  output logic [1:0]  state_o
);
  localparam int NUM_LANES = 2;

  slot_t [NUM_LANES-1:0]      slot;
  logic  [NUM_LANES-1:0]      s_valid, i_valid, i_accept, accept;
  logic  [NUM_LANES-1:0][14:0] lane_regs;
  logic  [NUM_LANES-1:0]      lane_rdv, lane_md, rd_wr, hazard, sb_set;
  logic  [NUM_LANES-1:0][4:0] rs1, rs2, rd;

  state_e      state_q;
  logic [31:0] sb_q, sb_set_vec, sb_clr_vec, dual_cnt_q;
  logic        serial0, pair_blk, sb_empty;

  assign slot[0]  = '{instr: slot0_instr_i, pc: slot0_pc_i, cls: slot0_class_i};
  assign slot[1]  = '{instr: slot1_instr_i, pc: slot1_pc_i, cls: slot1_class_i};
  assign s_valid  = {slot1_valid_i, slot0_valid_i};
  assign i_accept = {issue1_accept_i, issue0_accept_i};

  always_comb begin
    lane_regs = '0;
    lane_rdv  = '0;
    lane_md   = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      lane_regs[n] = {slot[n].instr[24:15], slot[n].instr[11:7]};
      lane_rdv[n]  = slot[n].cls[C_RDV];
      lane_md[n]   = slot[n].cls[C_MUL] | slot[n].cls[C_DIV];
    end
  end

  issue_sched_lane u_lane [NUM_LANES-1:0] (
    .regs     (lane_regs),
    .rd_valid (lane_rdv),
    .muldiv   (lane_md),
    .pend     (sb_q),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .rd_wr    (rd_wr),
    .hazard   (hazard),
    .sb_set   (sb_set)
  );

  assign serial0  = slot[0].cls[C_CSR] | slot[0].cls[C_INV];
  assign pair_blk = (slot[0].cls[C_LSU] & slot[1].cls[C_LSU])
                  | (lane_md[0] & lane_md[1])
                  | serial0 | slot[1].cls[C_CSR] | slot[1].cls[C_INV]
                  | slot[0].cls[C_BR]
                  | (rd_wr[0] & ((rd[0] == rs1[1]) | (rd[0] == rs2[1]) | (rd[0] == rd[1])));

  // Lane 1 needs lane 0 actually taken, so order holds even if pipe 0 stalls.
  always_comb begin
    i_valid = '0;
    if (rst_ni && !branch_request_i) begin
      unique case (state_q)
        RUN: begin
          i_valid[0] = s_valid[0] & ~serial0 & ~hazard[0];
          i_valid[1] = i_valid[0] & i_accept[0] & s_valid[1] & ~pair_blk & ~hazard[1];
        end
        SERIAL:  i_valid[0] = s_valid[0] & ~hazard[0];
        default: ;
      endcase
    end
  end

  assign accept = i_valid & i_accept;

  always_comb begin
    sb_set_vec = '0;
    sb_clr_vec = '0;
    for (int n = 0; n < NUM_LANES; n++)
      if (accept[n] && sb_set[n]) sb_set_vec[rd[n]] = 1'b1;
    if (wb_valid_i) sb_clr_vec[wb_rd_i] = 1'b1;
  end

  assign sb_empty = ~|sb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      sb_q       <= '0;
      dual_cnt_q <= '0;
    end else begin
      // set applied after clear so a same-cycle collision stays pending
      sb_q <= (sb_q & ~sb_clr_vec) | sb_set_vec;
      if (&accept) dual_cnt_q <= dual_cnt_q + 32'd1;
      if (branch_request_i) begin
        state_q <= RUN;
      end else begin
        unique case (state_q)
          RUN:    if (s_valid[0] && serial0)     state_q <= DRAIN;
          DRAIN:  if (pipe_idle_i && sb_empty)   state_q <= SERIAL;
          SERIAL: if (accept[0])                 state_q <= WAIT;
          WAIT:   if (pipe_idle_i)               state_q <= RUN;
          default:                               state_q <= RUN;
        endcase
      end
    end
  end

  assign issue0_valid_o = i_valid[0];
  assign issue1_valid_o = i_valid[1];
  assign slot0_accept_o = accept[0];
  assign slot1_accept_o = accept[1];
  assign issue0_instr_o = slot[0].instr;
  assign issue0_pc_o    = slot[0].pc;
  assign issue0_class_o = slot[0].cls;
  assign issue1_instr_o = slot[1].instr;
  assign issue1_pc_o    = slot[1].pc;
  assign issue1_class_o = slot[1].cls;
  assign dual_cnt_o     = dual_cnt_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_issue_sched.sv
// Directed + random checks of issue_sched against an abstract issue-rule model.
module tb_issue_sched;
  logic        clk_i, rst_ni;
  logic        slot0_valid_i, slot1_valid_i;
  logic [31:0] slot0_instr_i, slot0_pc_i, slot1_instr_i, slot1_pc_i;
  logic [7:0]  slot0_class_i, slot1_class_i;
  logic        slot0_accept_o, slot1_accept_o;
  logic        issue0_valid_o, issue1_valid_o;
  logic [31:0] issue0_instr_o, issue0_pc_o, issue1_instr_o, issue1_pc_o;
  logic [7:0]  issue0_class_o, issue1_class_o;
  logic        issue0_accept_i, issue1_accept_i;
  logic        wb_valid_i, branch_request_i, pipe_idle_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] dual_cnt_o;
  logic [1:0]  state_o;

  issue_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slot0_valid_i(slot0_valid_i), .slot0_instr_i(slot0_instr_i), .slot0_pc_i(slot0_pc_i),
    .slot0_class_i(slot0_class_i), .slot0_accept_o(slot0_accept_o),
    .slot1_valid_i(slot1_valid_i), .slot1_instr_i(slot1_instr_i), .slot1_pc_i(slot1_pc_i),
    .slot1_class_i(slot1_class_i), .slot1_accept_o(slot1_accept_o),
    .issue0_valid_o(issue0_valid_o), .issue0_instr_o(issue0_instr_o), .issue0_pc_o(issue0_pc_o),
    .issue0_class_o(issue0_class_o), .issue0_accept_i(issue0_accept_i),
    .issue1_valid_o(issue1_valid_o), .issue1_instr_o(issue1_instr_o), .issue1_pc_o(issue1_pc_o),
    .issue1_class_o(issue1_class_o), .issue1_accept_i(issue1_accept_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .branch_request_i(branch_request_i), .pipe_idle_i(pipe_idle_i),
    .dual_cnt_o(dual_cnt_o), .state_o(state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam logic [31:0] ADDI = 32'h00100093, ADD = 32'h00628233, LW = 32'h0000A103;
  localparam logic [31:0] MUL  = 32'h022081B3, ADD53 = 32'h000182B3, CSRW = 32'h30009073;
  localparam logic [7:0]  C_ALU = 8'h41, C_LD = 8'h42, C_MULR = 8'h48, C_CSRC = 8'h20;

  // Reference model: state number, pending register list, dual-issue count
  int          m_state;
  bit          m_pend [32];
  logic [31:0] m_cnt;
  int          n_checks, n_fail;
  logic        o_v0, o_v1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit busy(input logic [31:0] ins, input logic [7:0] cl);
    int a, b, d;
    a = int'(ins[19:15]); b = int'(ins[24:20]); d = int'(ins[11:7]);
    return m_pend[a] || m_pend[b] || (cl[6] && m_pend[d]);
  endfunction

  function automatic bit pair_ok(input logic [31:0] i0, input logic [7:0] c0,
                                 input logic [31:0] i1, input logic [7:0] c1);
    logic [4:0] d0;
    d0 = i0[11:7];
    if (c0[1] && c1[1]) return 0;
    if ((c0[3] || c0[4]) && (c1[3] || c1[4])) return 0;
    if (c0[5] || c0[7] || c1[5] || c1[7] || c0[2]) return 0;
    if (c0[6] && d0 != 0 && (d0 == i1[19:15] || d0 == i1[24:20] || d0 == i1[11:7])) return 0;
    return 1;
  endfunction

  function automatic bit pend_empty();
    foreach (m_pend[k]) if (m_pend[k]) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = '0;
    foreach (m_pend[k]) m_pend[k] = 0;
  endtask

  task automatic claim(input bit a, input logic [31:0] ins, input logic [7:0] cl);
    if (a && (cl[3] || cl[4]) && cl[6] && ins[11:7] != 5'd0) m_pend[int'(ins[11:7])] = 1;
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model.
  task automatic step();
    bit e0, e1, a0, a1, empty;
    @(negedge clk_i);
    e0 = 0; e1 = 0;
    if (rst_ni && !branch_request_i) begin
      if (m_state == 0) begin
        e0 = slot0_valid_i && !(slot0_class_i[5] || slot0_class_i[7]) && !busy(slot0_instr_i, slot0_class_i);
        e1 = e0 && issue0_accept_i && slot1_valid_i && !busy(slot1_instr_i, slot1_class_i)
             && pair_ok(slot0_instr_i, slot0_class_i, slot1_instr_i, slot1_class_i);
      end else if (m_state == 2) begin
        e0 = slot0_valid_i && !busy(slot0_instr_i, slot0_class_i);
      end
    end
    a0 = e0 && issue0_accept_i;
    a1 = e1 && issue1_accept_i;
    o_v0 = issue0_valid_o; o_v1 = issue1_valid_o;
    chk("issue0_valid", issue0_valid_o, e0);
    chk("issue1_valid", issue1_valid_o, e1);
    chk("slot0_accept", slot0_accept_o, a0);
    chk("slot1_accept", slot1_accept_o, a1);
    chk("state", state_o, m_state);
    chk("dual_cnt", dual_cnt_o, m_cnt);
    chk("pass0", {issue0_instr_o ^ issue0_pc_o, issue0_class_o} == {slot0_instr_i ^ slot0_pc_i, slot0_class_i}, 1);
    chk("pass1", {issue1_instr_o ^ issue1_pc_o, issue1_class_o} == {slot1_instr_i ^ slot1_pc_i, slot1_class_i}, 1);
    @(posedge clk_i);
    if (!rst_ni) model_reset();
    else begin
      empty = pend_empty();
      if (branch_request_i) m_state = 0;
      else case (m_state)
        0: if (slot0_valid_i && (slot0_class_i[5] || slot0_class_i[7])) m_state = 1;
        1: if (pipe_idle_i && empty) m_state = 2;
        2: if (a0) m_state = 3;
        default: if (pipe_idle_i) m_state = 0;
      endcase
      if (wb_valid_i) m_pend[int'(wb_rd_i)] = 0;
      claim(a0, slot0_instr_i, slot0_class_i);
      claim(a1, slot1_instr_i, slot1_class_i);
      if (a0 && a1) m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic slots(input bit v0, input logic [31:0] i0, input logic [7:0] c0,
                       input bit v1, input logic [31:0] i1, input logic [7:0] c1);
    slot0_valid_i = v0; slot0_instr_i = i0; slot0_class_i = c0; slot0_pc_i = $urandom;
    slot1_valid_i = v1; slot1_instr_i = i1; slot1_class_i = c1; slot1_pc_i = $urandom;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    r[19:15] = 5'($urandom_range(7));
    r[24:20] = 5'($urandom_range(7));
    r[11:7]  = 5'($urandom_range(7));
    return r;
  endfunction

  function automatic logic [7:0] rnd_class();
    logic [7:0] c;
    c = 8'($urandom) & 8'h5F;
    if ($urandom_range(15) == 0) c[5] = 1'b1;
    if ($urandom_range(31) == 0) c[7] = 1'b1;
    return c;
  endfunction

  initial begin
    n_checks = 0; n_fail = 0;
    model_reset();
    rst_ni = 1'b0;
    slots(1, ADDI, C_ALU, 1, ADD, C_ALU);
    issue0_accept_i = 1; issue1_accept_i = 1;
    wb_valid_i = 0; wb_rd_i = '0; branch_request_i = 0; pipe_idle_i = 1;
    #3;
    chk("rst_valid0", issue0_valid_o, 0);
    chk("rst_accept1", slot1_accept_o, 0);
    chk("rst_cnt", dual_cnt_o, 0);
    step();
    rst_ni = 1'b1;

    // Independent pair dual-issues
    step();
    chk("indep_both", {o_v0, o_v1}, 2'b11);
    chk("indep_cnt", dual_cnt_o, 1);

    // RAW pair: LW reads x1 written by ADDI
    slots(1, ADDI, C_ALU, 1, LW, C_LD);
    step();
    chk("raw_only0", {o_v0, o_v1}, 2'b10);
    slots(1, LW, C_LD, 0, ADD, C_ALU);
    step();
    chk("raw_lw_issues", o_v0, 1);
    chk("raw_cnt", dual_cnt_o, 1);

    // Scoreboard on MUL x3
    slots(1, MUL, C_MULR, 0, ADD, C_ALU);
    step();
    slots(1, ADD53, C_ALU, 0, ADD, C_ALU);
    step();
    chk("sb_stall1", o_v0, 0);
    step();
    chk("sb_stall2", o_v0, 0);
    wb_valid_i = 1; wb_rd_i = 5'd3;
    step();
    chk("sb_stall_wb", o_v0, 0);
    wb_valid_i = 0;
    step();
    chk("sb_issue_after", o_v0, 1);

    // CSR serialization
    pipe_idle_i = 0;
    slots(1, CSRW, C_CSRC, 1, ADD, C_ALU);
    step();
    chk("csr_noissue", {o_v0, o_v1}, 2'b00);
    chk("csr_drain", state_o, 1);
    step();
    chk("csr_hold_drain", state_o, 1);
    pipe_idle_i = 1;
    step();
    chk("csr_serial", state_o, 2);
    pipe_idle_i = 0;
    step();
    chk("csr_issue0_only", {o_v0, o_v1}, 2'b10);
    chk("csr_wait", state_o, 3);
    slots(0, ADDI, C_ALU, 0, ADD, C_ALU);
    step();
    chk("csr_hold_wait", state_o, 3);
    pipe_idle_i = 1;
    step();
    chk("csr_run", state_o, 0);

    // Same-cycle MUL set and wb clear of x3 leaves x3 pending
    slots(1, MUL, C_MULR, 0, ADD, C_ALU);
    wb_valid_i = 1; wb_rd_i = 5'd3;
    step();
    wb_valid_i = 0;
    slots(1, ADD53, C_ALU, 0, ADD, C_ALU);
    step();
    chk("set_wins", o_v0, 0);

    // Flush while in DRAIN
    pipe_idle_i = 0;
    slots(1, CSRW, C_CSRC, 0, ADD, C_ALU);
    step();
    chk("flush_pre_drain", state_o, 1);
    slots(1, ADDI, C_ALU, 1, ADD, C_ALU);
    branch_request_i = 1;
    step();
    chk("flush_valids", {o_v0, o_v1}, 2'b00);
    chk("flush_run", state_o, 0);
    branch_request_i = 0;
    slots(1, ADD53, C_ALU, 0, ADD, C_ALU);
    step();
    chk("flush_keeps_x3", o_v0, 0);
    wb_valid_i = 1; wb_rd_i = 5'd3; pipe_idle_i = 1;
    slots(0, ADDI, C_ALU, 0, ADD, C_ALU);
    step();
    wb_valid_i = 0;

    // Counter wrap
    force dut.dual_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.dual_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    slots(1, ADDI, C_ALU, 1, ADD, C_ALU);
    step();
    chk("cnt_wrap", dual_cnt_o, 0);

    // Reach WAIT then reset asynchronously
    slots(1, CSRW, C_CSRC, 0, ADD, C_ALU);
    step();
    step();
    pipe_idle_i = 0;
    step();
    chk("pre_rst_wait", state_o, 3);
    slots(1, ADDI, C_ALU, 1, ADD, C_ALU);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_state", state_o, 0);
    chk("arst_valids", {issue0_valid_o, issue1_valid_o}, 2'b00);
    chk("arst_accepts", {slot0_accept_o, slot1_accept_o}, 2'b00);
    model_reset();
    step();
    rst_ni = 1'b1;

    // Random traffic against the model
    for (int t = 0; t < 600; t++) begin
      slots($urandom_range(4) != 0, rnd_instr(), rnd_class(),
            $urandom_range(4) != 0, rnd_instr(), rnd_class());
      issue0_accept_i  = $urandom_range(4) != 0;
      issue1_accept_i  = $urandom_range(4) != 0;
      wb_valid_i       = $urandom_range(2) == 0;
      wb_rd_i          = 5'($urandom_range(7));
      branch_request_i = $urandom_range(19) == 0;
      pipe_idle_i      = $urandom_range(1) == 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 SHALL have ports: clk_i in 1, sole clock, all state on rising edge; rst_ni in 1, asynchronous active-low reset.
REQ-002 SHALL have slotN_valid_i in 1, slotN_instr_i in 32, slotN_pc_i in 32, slotN_class_i in 8, and slotN_accept_o out 1, for N=0,1; these connect to decode output lanes 0/1.
REQ-003 SHALL encode class bits as [0]exec [1]lsu [2]branch [3]mul [4]div [5]csr [6]rd_valid [7]invalid; decode faults are ORed into bit 7 before this block.
REQ-004 SHALL have issueN_valid_o out 1, issueN_instr_o out 32, issueN_pc_o out 32, issueN_class_o out 8, and issueN_accept_i in 1, for N=0,1, toward execute pipes 0/1.
REQ-005 SHALL have wb_valid_i in 1 and wb_rd_i in 5: long-latency (mul/div) writeback retiring rd.
REQ-006 SHALL have branch_request_i in 1, execute redirect/flush; and pipe_idle_i in 1, all execute pipes empty.
REQ-007 SHALL have dual_cnt_o out 32, count of dual-issue cycles; and state_o out 2, FSM state.

Function
REQ-010 Issue order SHALL be strictly in order: slot1 issues only in a cycle where slot0 also issues.
REQ-011 slotN_accept_o SHALL equal issueN_valid_o & issueN_accept_i; the datapath is combinational (zero latency), with no internal instruction buffering.
REQ-012 issue0_valid_o SHALL be 0 when slot0 has a scoreboard hazard: rs1 (instr[19:15]), rs2 (instr[24:20]) or rd (instr[11:7] when rd_valid) pending; x0 SHALL never be pending.
REQ-013 issue1_valid_o SHALL be 0 unless slot0 issues and none of these pair blocks holds: both lsu; both in {mul,div}; either csr or invalid; slot0 branch; slot0 rd_valid with rd!=0 and rd equal to slot1 rs1/rs2/rd; slot1 scoreboard hazard.
REQ-014 Scoreboard: 32x1 pending bits; a mul/div with rd_valid and rd!=0 SHALL set bit rd on the accept cycle; wb_valid_i SHALL clear bit wb_rd_i.
REQ-015 A same-cycle set and clear of one bit SHALL resolve as set.
REQ-016 FSM states SHALL be RUN=0, DRAIN=1, SERIAL=2, WAIT=3.
REQ-017 In RUN, slot0 csr or invalid with slot0_valid_i SHALL suppress issue and go to DRAIN.
REQ-018 DRAIN SHALL go to SERIAL when pipe_idle_i=1 and the scoreboard is empty.
REQ-019 SERIAL SHALL issue slot0 alone and go to WAIT when it is accepted.
REQ-020 WAIT SHALL go to RUN when pipe_idle_i=1.
REQ-021 branch_request_i=1 SHALL force issue0/1_valid_o=0 that cycle and FSM to RUN next edge; scoreboard SHALL be retained because in-flight mul/div still write back.
REQ-022 dual_cnt_o SHALL increment when both slots are accepted in the same cycle, and SHALL wrap 0xFFFFFFFF->0.
REQ-023 issueN_instr/pc/class_o SHALL pass through slotN inputs regardless of valid.

Reset
REQ-030 While rst_ni=0: FSM=RUN, scoreboard all clear, dual_cnt_o=0, issue0/1_valid_o=0, slot0/1_accept_o=0; state SHALL be held until the first rising edge after deassertion.
REQ-031 Reset asserted mid-DRAIN/SERIAL/WAIT SHALL return to RUN immediately, discarding scoreboard contents.

Verification
REQ-040 Independent pair: slot0 ADDI x1,x0,1 (0x00100093), slot1 ADD x4,x5,x6 (0x00628233), both accepts=1 -> both issue, both accepts high, dual_cnt_o 0->1.
REQ-041 RAW pair: slot0 0x00100093, slot1 LW x2,0(x1) (0x0000A103) -> cycle1 only issue0 valid; next cycle LW presented in slot0 issues; dual_cnt_o unchanged.
REQ-042 Scoreboard: issue MUL x3,x1,x2 (0x022081B3); next cycle ADD x5,x3,x0 stalls until wb_valid_i=1 and wb_rd_i=3; ADD issues the cycle after the clear; same-cycle MUL set plus wb clear of x3 leaves x3 pending.
REQ-043 CSR serialization: slot0 CSRRW x0,mstatus,x1 (0x30009073) with pipe_idle_i=0 -> state_o=1, no issue; pipe_idle_i=1 -> state_o=2, issue0 only; after accept state_o=3, then 0 once pipe idle.
REQ-044 Flush: branch_request_i=1 while in DRAIN -> both issue valids 0 that cycle, state_o=0 next cycle; pending x3 still set.
REQ-045 Reset/wrap: force dual_cnt_o to 0xFFFFFFFF, dual issue -> 0x00000000; assert rst_ni=0 mid-WAIT -> state_o=0 and outputs 0 asynchronously.
